// File: rtl/interrupt_ack_sequencer_if.sv
// Handshake and bus signals between the interrupt acknowledge sequencer,
// the interrupt controller and the CPU core.
interface interrupt_ack_sequencer_if;
    logic        int_in;
    logic        int_enable;
    logic        mode_8086;
    logic [7:0]  data_bus_in;
    logic        inta_n;
    logic        busy;
    logic        vector_valid;
    logic        vector_ready;
    logic [7:0]  vector;
    logic [15:0] call_addr;
    logic        bad_opcode;

    modport master (
        input  int_in, int_enable, mode_8086, data_bus_in, vector_ready,
        output inta_n, busy, vector_valid, vector, call_addr, bad_opcode
    );

    modport slave (
        output int_in, int_enable, mode_8086, data_bus_in, vector_ready,
        input  inta_n, busy, vector_valid, vector, call_addr, bad_opcode
    );
endinterface

// File: rtl/interrupt_ack_sequencer.sv
// CPU-side INTA sequencer: issues the 8086 (two) or 8080 (three) INTA_n pulse
// train, captures the controller's bytes and delivers vector/CALL address.
module interrupt_ack_sequencer #(
    parameter int INTA_LOW_CYCLES = 2,
    parameter int INTA_GAP_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    interrupt_ack_sequencer_if.master   bus
);
    localparam int MAXC = (INTA_LOW_CYCLES > INTA_GAP_CYCLES) ? INTA_LOW_CYCLES : INTA_GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] LOW_LOAD = CW'(INTA_LOW_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(INTA_GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOW     = 2'd1,
        ST_GAP     = 2'd2,
        ST_DELIVER = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [1:0]    pulse_no_r, pulse_no_s;
    logic          mode_8086_r, mode_8086_s;
    logic [7:0]    byte1_r, byte1_s;
    logic [7:0]    byte2_r, byte2_s;
    logic          bad_r, bad_s;
    logic [7:0]    vector_r, vector_s;
    logic [15:0]   call_addr_r, call_addr_s;
    logic          last_pulse_s;

    logic          inta_n_r;
    logic          busy_r;
    logic          vector_valid_r;
    logic          bad_opcode_r;

    // Next-state, capture and result computation
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        pulse_no_s  = pulse_no_r;
        mode_8086_s = mode_8086_r;
        byte1_s     = byte1_r;
        byte2_s     = byte2_r;
        bad_s       = bad_r;
        vector_s    = vector_r;
        call_addr_s = call_addr_r;
        last_pulse_s = mode_8086_r ? (pulse_no_r == 2'd2) : (pulse_no_r == 2'd3);

        case (state_r)
            ST_IDLE: begin
                if (bus.int_in && bus.int_enable) begin
                    state_s     = ST_LOW;
                    cnt_s       = LOW_LOAD;
                    pulse_no_s  = 2'd1;
                    mode_8086_s = bus.mode_8086;
                    bad_s       = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (cnt_r == {CW{1'b0}}) begin
                    case (pulse_no_r)
                        2'd1: begin
                            byte1_s = bus.data_bus_in;
                            bad_s   = !mode_8086_r && (bus.data_bus_in != 8'hCD);
                        end
                        2'd2:    byte2_s = bus.data_bus_in;
                        default: byte2_s = byte2_r;
                    endcase
                    if (last_pulse_s) begin
                        state_s = ST_DELIVER;
                        // The final byte is still on the bus, so results are built from it directly.
                        if (mode_8086_r) begin
                            vector_s    = bus.data_bus_in;
                            call_addr_s = 16'h0000;
                        end else if (!bad_r) begin
                            vector_s    = byte1_r;
                            call_addr_s = {bus.data_bus_in, byte2_r};
                        end else begin
                            vector_s    = vector_r;
                        end
                    end else begin
                        state_s = ST_GAP;
                        cnt_s   = GAP_LOAD;
                    end
                end else begin
                    cnt_s = cnt_r - CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_s    = ST_LOW;
                    cnt_s      = LOW_LOAD;
                    pulse_no_s = pulse_no_r + 2'd1;
                end else begin
                    cnt_s = cnt_r - CW'(1);
                end
            end
            ST_DELIVER: begin
                if (bad_r || bus.vector_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DELIVER;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, captured bytes and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            cnt_r          <= {CW{1'b0}};
            pulse_no_r     <= 2'd0;
            mode_8086_r    <= 1'b0;
            byte1_r        <= 8'h00;
            byte2_r        <= 8'h00;
            bad_r          <= 1'b0;
            vector_r       <= 8'h00;
            call_addr_r    <= 16'h0000;
            inta_n_r       <= 1'b1;
            busy_r         <= 1'b0;
            vector_valid_r <= 1'b0;
            bad_opcode_r   <= 1'b0;
        end else begin
            state_r        <= state_s;
            cnt_r          <= cnt_s;
            pulse_no_r     <= pulse_no_s;
            mode_8086_r    <= mode_8086_s;
            byte1_r        <= byte1_s;
            byte2_r        <= byte2_s;
            bad_r          <= bad_s;
            vector_r       <= vector_s;
            call_addr_r    <= call_addr_s;
            inta_n_r       <= (state_s != ST_LOW);
            busy_r         <= (state_s != ST_IDLE);
            vector_valid_r <= (state_s == ST_DELIVER) && !bad_s;
            bad_opcode_r   <= (state_s == ST_DELIVER) && bad_s;
        end
    end

    assign bus.inta_n       = inta_n_r;
    assign bus.busy         = busy_r;
    assign bus.vector_valid = vector_valid_r;
    assign bus.vector       = vector_r;
    assign bus.call_addr    = call_addr_r;
    assign bus.bad_opcode   = bad_opcode_r;
endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Directed bench for interrupt_ack_sequencer: table of acknowledge sequences
// plus hand-written reset, backpressure and masking sequences.
module tb_interrupt_ack_sequencer;
    localparam int L = 2;
    localparam int G = 2;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    interrupt_ack_sequencer_if bus_if ();

    interrupt_ack_sequencer #(
        .INTA_LOW_CYCLES (L),
        .INTA_GAP_CYCLES (G)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
        logic [7:0]  exp_vec;
        logic [15:0] exp_call;
        logic        exp_bad;
        logic        disturb;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which INTA pulse (1..n) has inta_n low in cycle c; 0 if none.
    function automatic int pulse_of(input int c, input int n);
        for (int k = 1; k <= n; k++) begin
            int s;
            s = 1 + (k - 1) * (L + G);
            if (c >= s && c <= s + L - 1) return k;
        end
        return 0;
    endfunction

    function automatic logic [7:0] byte_for(input vec_t v, input int k);
        case (k)
            1:       return v.b1;
            2:       return v.b2;
            3:       return v.b3;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        int d;
        int k;
        n = v.mode ? 2 : 3;
        d = n * L + (n - 1) * G + 1;
        bus_if.mode_8086    = v.mode;
        bus_if.int_enable   = 1'b1;
        bus_if.int_in       = 1'b1;
        bus_if.vector_ready = 1'b0;
        bus_if.data_bus_in  = 8'hFF;
        for (int c = 0; c <= d + 1; c++) begin
            if (c > 0) @(negedge clk);
            if (c == L + 1) bus_if.int_in = 1'b0;
            if (v.disturb && c == 2) begin
                bus_if.mode_8086  = ~v.mode;
                bus_if.int_enable = 1'b0;
            end
            k = pulse_of(c, n);
            bus_if.data_bus_in  = byte_for(v, k);
            bus_if.vector_ready = (c == d);
            chk($sformatf("v%0d_inta_n_c%0d", idx, c), 32'(bus_if.inta_n), 32'(k == 0));
            if (c < d) begin
                chk($sformatf("v%0d_valid_c%0d", idx, c), 32'(bus_if.vector_valid), 32'd0);
                chk($sformatf("v%0d_bad_c%0d", idx, c), 32'(bus_if.bad_opcode), 32'd0);
                chk($sformatf("v%0d_busy_c%0d", idx, c), 32'(bus_if.busy), 32'(c >= 1));
            end else if (c == d) begin
                chk($sformatf("v%0d_valid_d", idx), 32'(bus_if.vector_valid), 32'(!v.exp_bad));
                chk($sformatf("v%0d_badop_d", idx), 32'(bus_if.bad_opcode), 32'(v.exp_bad));
                chk($sformatf("v%0d_busy_d", idx), 32'(bus_if.busy), 32'd1);
                if (!v.exp_bad) begin
                    chk($sformatf("v%0d_vector", idx), 32'(bus_if.vector), 32'(v.exp_vec));
                    chk($sformatf("v%0d_call", idx), 32'(bus_if.call_addr), 32'(v.exp_call));
                end
            end else begin
                chk($sformatf("v%0d_busy_idle", idx), 32'(bus_if.busy), 32'd0);
                chk($sformatf("v%0d_valid_idle", idx), 32'(bus_if.vector_valid), 32'd0);
                chk($sformatf("v%0d_badop_idle", idx), 32'(bus_if.bad_opcode), 32'd0);
            end
        end
        bus_if.vector_ready = 1'b0;
        bus_if.int_enable   = 1'b1;
        bus_if.data_bus_in  = 8'hFF;
    endtask

    initial begin
        int  d;
        int  k;
        logic done;
        vec_t bp;

        n_tests = 0;
        n_fail  = 0;
        //             mode  b1     b2     b3     vec    call       bad   disturb
        tbl[0] = '{1'b1, 8'h00, 8'h4A, 8'h00, 8'h4A, 16'h0000, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 8'hCD, 8'h34, 8'h12, 8'hCD, 16'h1234, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 8'hC3, 8'h34, 8'h12, 8'h00, 16'h0000, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 8'h77, 8'h08, 8'h99, 8'h08, 16'h0000, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 8'hCD, 8'hFF, 8'h00, 8'hCD, 16'h00FF, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 8'hCD, 8'h00, 8'hA5, 8'hCD, 16'hA500, 1'b0, 1'b1};

        reset               = 1'b1;
        bus_if.int_in       = 1'b0;
        bus_if.int_enable   = 1'b0;
        bus_if.mode_8086    = 1'b0;
        bus_if.data_bus_in  = 8'h00;
        bus_if.vector_ready = 1'b0;

        @(negedge clk);
        chk("rst_inta_n", 32'(bus_if.inta_n), 32'd1);
        chk("rst_busy", 32'(bus_if.busy), 32'd0);
        chk("rst_valid", 32'(bus_if.vector_valid), 32'd0);
        chk("rst_vector", 32'(bus_if.vector), 32'd0);
        chk("rst_call", 32'(bus_if.call_addr), 32'd0);
        chk("rst_badop", 32'(bus_if.bad_opcode), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_vec(tbl[i], i);
            @(negedge clk);
        end

        // Masking: INT held with interrupts disabled never starts a sequence.
        bus_if.int_enable = 1'b0;
        bus_if.int_in     = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("mask_inta_n_c%0d", c), 32'(bus_if.inta_n), 32'd1);
            chk($sformatf("mask_busy_c%0d", c), 32'(bus_if.busy), 32'd0);
        end
        bus_if.int_in     = 1'b0;
        bus_if.int_enable = 1'b1;
        @(negedge clk);

        // Backpressure: 8080 sequence, ready withheld, INT kept high throughout.
        bp = '{1'b0, 8'hCD, 8'h34, 8'h12, 8'hCD, 16'h1234, 1'b0, 1'b0};
        d  = 3 * L + 2 * G + 1;
        bus_if.mode_8086 = 1'b0;
        bus_if.int_in    = 1'b1;
        for (int c = 0; c <= d + 7; c++) begin
            if (c > 0) @(negedge clk);
            k = pulse_of(c, 3);
            bus_if.data_bus_in  = byte_for(bp, k);
            bus_if.vector_ready = (c == d + 5);
            if (c < d) begin
                chk($sformatf("bp_inta_n_c%0d", c), 32'(bus_if.inta_n), 32'(k == 0));
            end else if (c <= d + 5) begin
                chk($sformatf("bp_valid_c%0d", c), 32'(bus_if.vector_valid), 32'd1);
                chk($sformatf("bp_vector_c%0d", c), 32'(bus_if.vector), 32'hCD);
                chk($sformatf("bp_call_c%0d", c), 32'(bus_if.call_addr), 32'h1234);
                chk($sformatf("bp_inta_n_c%0d", c), 32'(bus_if.inta_n), 32'd1);
            end else if (c == d + 6) begin
                chk("bp_idle_busy", 32'(bus_if.busy), 32'd0);
                chk("bp_idle_valid", 32'(bus_if.vector_valid), 32'd0);
                chk("bp_idle_inta_n", 32'(bus_if.inta_n), 32'd1);
            end else begin
                chk("bp_restart_inta_n", 32'(bus_if.inta_n), 32'd0);
                chk("bp_restart_busy", 32'(bus_if.busy), 32'd1);
            end
        end
        bus_if.int_in       = 1'b0;
        bus_if.data_bus_in  = 8'hCD;
        bus_if.vector_ready = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!bus_if.busy) done = 1'b1;
        end
        chk("bp_drain_done", 32'(done), 32'd1);
        bus_if.vector_ready = 1'b0;
        @(negedge clk);

        // Reset in the middle of the first INTA pulse.
        bus_if.mode_8086 = 1'b1;
        bus_if.int_in    = 1'b1;
        @(negedge clk);
        chk("mrst_inta_n_c1", 32'(bus_if.inta_n), 32'd0);
        @(negedge clk);
        chk("mrst_inta_n_c2", 32'(bus_if.inta_n), 32'd0);
        reset         = 1'b1;
        bus_if.int_in = 1'b0;
        @(negedge clk);
        chk("mrst_inta_n", 32'(bus_if.inta_n), 32'd1);
        chk("mrst_busy", 32'(bus_if.busy), 32'd0);
        chk("mrst_valid", 32'(bus_if.vector_valid), 32'd0);
        chk("mrst_vector", 32'(bus_if.vector), 32'd0);
        chk("mrst_call", 32'(bus_if.call_addr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("mrst_quiet_inta_n_c%0d", c), 32'(bus_if.inta_n), 32'd1);
            chk($sformatf("mrst_quiet_busy_c%0d", c), 32'(bus_if.busy), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
